muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit implementing the RISC-V M-extension operations. It is the sequential companion to the single-cycle integer ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake, computes over a fixed number of cycles set by a radix parameter, and returns the result over a second valid/ready handshake. The pipeline stalls on `busy`; `kill` lets the core abandon an in-flight operation on a trap or flush.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and restoring divide,
// BITS_PER_CYCLE bits per iteration, valid/ready request and response handshakes.
module muldiv_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       command,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int unsigned W    = WIDTH;
  localparam int unsigned Bpc  = BITS_PER_CYCLE;
  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      cmd_q;
  logic            fast_q;
  logic            neg_q;
  logic [W-1:0]    opnd_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    res_q;

  // Request decode, evaluated on the raw inputs for the accept edge.
  logic         a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, ovf, fast_in, neg_in;
  logic [W-1:0] mag_a, mag_b, fast_res;

  always_comb begin
    a_sgn    = (command == 3'd1) || (command == 3'd2) || (command == 3'd4) || (command == 3'd6);
    b_sgn    = (command == 3'd1) || (command == 3'd4) || (command == 3'd6);
    a_neg    = a_sgn & in1[W-1];
    b_neg    = b_sgn & in2[W-1];
    mag_a    = a_neg ? -in1 : in1;
    mag_b    = b_neg ? -in2 : in2;
    is_div   = command[2];
    div_zero = is_div && (in2 == '0);
    ovf      = ((command == 3'd4) || (command == 3'd6)) && (in1 == MinVal) && (in2 == '1);
    fast_in  = div_zero || ovf;
    // Remainder follows the dividend sign; everything else uses the product/quotient sign.
    neg_in   = (command[2] & command[1]) ? a_neg : (a_neg ^ b_neg);
    if (div_zero) begin
      fast_res = command[1] ? in1 : '1;
    end else begin
      fast_res = command[1] ? '0 : in1;
    end
  end

  // One multiply iteration: add multiplicand times the low multiplier bits, shift right.
  logic [W+Bpc-1:0] mul_sum;
  logic [2*W-1:0]   mul_next;

  always_comb begin
    mul_sum  = {{Bpc{1'b0}}, acc_q[2*W-1:W]} +
               ({{Bpc{1'b0}}, opnd_q} * {{W{1'b0}}, acc_q[Bpc-1:0]});
    mul_next = {mul_sum, acc_q[W-1:Bpc]};
  end

  // One divide iteration: Bpc restoring steps on {remainder, dividend/quotient}.
  logic [W:0]     dv_r;
  logic [W-1:0]   dv_rem, dv_quo;
  logic [2*W-1:0] div_next;

  always_comb begin
    dv_r   = '0;
    dv_rem = acc_q[2*W-1:W];
    dv_quo = acc_q[W-1:0];
    for (int k = 0; k < Bpc; k++) begin
      dv_r   = {dv_rem, dv_quo[W-1]};
      dv_quo = {dv_quo[W-2:0], 1'b0};
      if (dv_r >= {1'b0, opnd_q}) begin
        dv_r      = dv_r - {1'b0, opnd_q};
        dv_quo[0] = 1'b1;
      end
      dv_rem = dv_r[W-1:0];
    end
    div_next = {dv_rem, dv_quo};
  end

  // Sign fix-up and result select, applied on the final edge.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix  = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    fix_res  = '0;
    if (fast_q) begin
      fix_res = acc_q[W-1:0];
    end else begin
      case (cmd_q)
        3'd0:                fix_res = prod_fix[W-1:0];
        3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*W-1:W];
        3'd4, 3'd5:          fix_res = quo_fix;
        default:             fix_res = rem_fix;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cmd_q   <= '0;
      fast_q  <= 1'b0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else if (kill) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            cmd_q   <= command;
            fast_q  <= fast_in;
            neg_q   <= neg_in;
            opnd_q  <= is_div ? mag_b : mag_a;
            // Fast path skips the iterations and only takes the result edge.
            cnt_q   <= fast_in ? '0 : CntW'(N);
            acc_q   <= fast_in ? {{W{1'b0}}, fast_res} : {{W{1'b0}}, is_div ? mag_a : mag_b};
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (cnt_q != '0) begin
            acc_q <= cmd_q[2] ? div_next : mul_next;
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            res_q   <= fix_res;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) && rst_n;
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign out       = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: one radix-1 and one radix-4 instance share the stimulus,
// expected results and latencies are queued at issue and checked by a separate monitor.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        kill = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  command = 3'd0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;

  logic        iv1, iv4, rdy1, rdy4, ov1, ov4, busy1, busy4;
  logic [31:0] o1, o4;
  logic        rdy_s, ov_s, busy_s;
  logic [31:0] out_s;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign iv1    = in_valid & ~sel;
  assign iv4    = in_valid & sel;
  assign rdy_s  = sel ? rdy4 : rdy1;
  assign ov_s   = sel ? ov4 : ov1;
  assign busy_s = sel ? busy4 : busy1;
  assign out_s  = sel ? o4 : o1;

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .in1(in1), .in2(in2),
    .command(command), .kill(kill), .out_valid(ov1), .out_ready(out_ready), .out(o1),
    .busy(busy1)
  );

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .in1(in1), .in2(in2),
    .command(command), .kill(kill), .out_valid(ov4), .out_ready(out_ready), .out(o4),
    .busy(busy4)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: compares value and latency when out_valid rises.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov_s && !ov_prev) begin
      if (q.size() == 0) begin
        chk("unexpected out_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk(e.nm, out_s, e.res);
        chk({e.nm, " latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    ov_prev = ov_s;
  end

  task automatic issue(input bit s, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit push, input string nm);
    int   t;
    exp_t e;
    t   = 0;
    sel = s;
    @(negedge clk);
    while (!rdy_s && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rdy_s) begin
      chk({nm, " ready timeout"}, 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    command  = c;
    in1      = a;
    in2      = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.res = exp;
      e.lat = lat;
      e.acc = cyc;
      e.nm  = nm;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy_s) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain pending", 32'(q.size()), 32'd0);
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sa, sb, sr;
    sa = a;
    sb = b;
    sr = '0;
    case (c)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'd1: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp[63:32];
      end
      3'd2: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
        return sp[63:32];
      end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sr = sa / sb;
        return sr;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sr = sa % sb;
        return sr;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input int n);
    if (c[2] && b == 0) return 1;
    if ((c == 3'd4 || c == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return n + 1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, pending %0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  c;
    logic [31:0] a, b;
    int          t, nvalid;

    // Reset state, observed while reset is held.
    #3;
    chk("reset in_ready", {31'd0, rdy1}, 32'd0);
    chk("reset busy", {31'd0, busy1}, 32'd0);
    chk("reset out_valid", {31'd0, ov1}, 32'd0);
    chk("reset out", o1, 32'd0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", {31'd0, rdy1}, 32'd1);

    // Multiply signedness with all-ones operands, radix 1.
    issue(0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1, "mul -1*-1");
    issue(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1, "mulh -1*-1");
    issue(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1, "mulhu max*max");
    issue(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1, "mulhsu -1*max");
    issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1, "mul 7*-3");
    // Division.
    issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1, "div -7/2");
    issue(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1, "rem -7/2");
    issue(0, 3'd5, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 33, 1, "divu 0x80000000/3");
    issue(0, 3'd7, 32'h8000_0000, 32'd3, 32'h0000_0002, 33, 1, "remu 0x80000000/3");
    // Fast-path corners.
    issue(0, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, "div 5/0");
    issue(0, 3'd7, 32'd5, 32'd0, 32'h0000_0005, 1, 1, "remu 5/0");
    issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, "div ovf");
    issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1, "rem ovf");
    drain();

    // Backpressure: result held, new request ignored.
    out_ready = 1'b0;
    issue(0, 3'd0, 32'd3, 32'd5, 32'd15, 33, 1, "bp mul 3*5");
    t = 0;
    @(negedge clk);
    while (!ov1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("bp out_valid seen", {31'd0, ov1}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid = 1'b1;
        command  = 3'd0;
        in1      = 32'd9;
        in2      = 32'd9;
      end
      chk($sformatf("bp out stable %0d", i), o1, 32'd15);
      chk($sformatf("bp in_ready low %0d", i), {31'd0, rdy1}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp in_ready after consume", {31'd0, rdy1}, 32'd1);
    @(posedge clk);
    #1;
    chk("bp held request ignored", {31'd0, busy1}, 32'd0);

    // Request presented together with kill is not accepted.
    @(negedge clk);
    kill     = 1'b1;
    in_valid = 1'b1;
    command  = 3'd5;
    in1      = 32'd100;
    in2      = 32'd7;
    @(posedge clk);
    #1;
    kill     = 1'b0;
    in_valid = 1'b0;
    chk("kill blocks accept", {31'd0, busy1}, 32'd0);

    // Kill on edge 10 of a divu.
    issue(0, 3'd5, 32'd100, 32'd7, 32'd0, 0, 0, "killed divu");
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill busy", {31'd0, busy1}, 32'd0);
    chk("kill in_ready", {31'd0, rdy1}, 32'd1);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov1) nvalid++;
    end
    chk("kill no out_valid", 32'(nvalid), 32'd0);
    issue(0, 3'd5, 32'd100, 32'd7, 32'd14, 33, 1, "divu after kill");
    drain();

    // Asynchronous reset mid-CALC.
    issue(0, 3'd0, 32'd11, 32'd13, 32'd0, 0, 0, "reset-aborted mul");
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst busy", {31'd0, busy1}, 32'd0);
    chk("async rst out_valid", {31'd0, ov1}, 32'd0);
    chk("async rst out", o1, 32'd0);
    chk("async rst in_ready", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after async rst", {31'd0, rdy1}, 32'd1);

    // Radix 4: random operands over all commands against the reference model.
    for (int i = 0; i < 2000; i++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      issue(1, c, a, b, ref_res(c, a, b), ref_lat(c, a, b, 8), 1,
            $sformatf("r4 #%0d cmd%0d %h,%h", i, c, a, b));
    end
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
